// File: rtl/latch_load_if.sv
// Handshake and latch-drive bundle between a requester and latch_load_sequencer.
interface latch_load_if #(
    parameter int WIDTH = 4
);
    logic             WR_REQ;
    logic [WIDTH-1:0] WR_DATA;
    logic             PRE_REQ;
    logic             WR_ACK;
    logic             PRE_ACK;
    logic             BUSY;
    logic [WIDTH-1:0] LAT_D;
    logic             LAT_GN;
    logic             LAT_PRE;
    logic [WIDTH-1:0] SHADOW_Q;

    modport master (
        output WR_REQ, WR_DATA, PRE_REQ,
        input  WR_ACK, PRE_ACK, BUSY, LAT_D, LAT_GN, LAT_PRE, SHADOW_Q
    );

    modport slave (
        input  WR_REQ, WR_DATA, PRE_REQ,
        output WR_ACK, PRE_ACK, BUSY, LAT_D, LAT_GN, LAT_PRE, SHADOW_Q
    );
endinterface

// File: rtl/latch_load_sequencer.sv
// Write/preset sequencer for a bank of gate-low, async-preset transparent latches,
// with programmable setup/gate/hold/preset windows and a shadow of the latch contents.
module latch_load_sequencer #(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int PRE_CYC   = 2
) (
    input  logic          C,
    input  logic          CLRN,
    latch_load_if.slave   bus
);
    localparam int MAX_SG  = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
    localparam int MAX_HP  = (HOLD_CYC > PRE_CYC) ? HOLD_CYC : PRE_CYC;
    localparam int MAX_CYC = (MAX_SG > MAX_HP) ? MAX_SG : MAX_HP;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GATE_LD  = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);

    typedef enum logic [2:0] {INIT, IDLE, SETUP, GATE, HOLD, PRE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept_wr, gate_close, wr_done, pre_done;

    logic             wr_ack, pre_ack, busy, lat_gn, lat_pre;
    logic [WIDTH-1:0] lat_d, shadow;

    // Counter holds "cycles left minus one" and is reloaded on every state entry.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept_wr  = 1'b0;
        gate_close = 1'b0;
        wr_done    = 1'b0;
        pre_done   = 1'b0;
        case (state)
            INIT: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            IDLE: begin
                // The ACK cycle is a dead cycle so a held request is not re-accepted.
                if (!wr_ack && !pre_ack) begin
                    if (bus.PRE_REQ) begin
                        state_nxt = PRE;
                        cnt_nxt   = PRE_LD;
                    end else if (bus.WR_REQ) begin
                        state_nxt = SETUP;
                        cnt_nxt   = SETUP_LD;
                        accept_wr = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = GATE;
                    cnt_nxt   = GATE_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GATE: begin
                if (cnt == '0) begin
                    state_nxt  = HOLD;
                    cnt_nxt    = HOLD_LD;
                    gate_close = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    wr_done   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PRE: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    pre_done  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = PRE_LD;
            end
        endcase
    end

    // Latch drives are registered from the next state so they change cleanly on the clock.
    always_ff @(posedge C or negedge CLRN) begin
        if (!CLRN) begin
            state   <= INIT;
            cnt     <= PRE_LD;
            busy    <= 1'b1;
            lat_gn  <= 1'b1;
            lat_pre <= 1'b1;
            lat_d   <= '0;
            shadow  <= '1;
            wr_ack  <= 1'b0;
            pre_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            busy    <= (state_nxt != IDLE);
            lat_gn  <= (state_nxt != GATE);
            lat_pre <= (state_nxt == PRE) || (state_nxt == INIT);
            wr_ack  <= wr_done;
            pre_ack <= pre_done;
            if (accept_wr) lat_d <= bus.WR_DATA;
            if (gate_close)    shadow <= lat_d;
            else if (pre_done) shadow <= '1;
        end
    end

    assign bus.WR_ACK   = wr_ack;
    assign bus.PRE_ACK  = pre_ack;
    assign bus.BUSY     = busy;
    assign bus.LAT_D    = lat_d;
    assign bus.LAT_GN   = lat_gn;
    assign bus.LAT_PRE  = lat_pre;
    assign bus.SHADOW_Q = shadow;
endmodule

// File: tb/tb_latch_load_sequencer.sv
// Bench for latch_load_sequencer: fixed vector table, directed corner sequences and
// randomized requests checked against an operation-timeline reference model.
module tb_latch_load_sequencer;
    localparam int S = 1;
    localparam int G = 2;
    localparam int H = 1;
    localparam int P = 2;

    logic C;
    logic CLRN;
    latch_load_if #(.WIDTH(4)) bus ();

    latch_load_sequencer #(
        .WIDTH(4), .SETUP_CYC(S), .GATE_CYC(G), .HOLD_CYC(H), .PRE_CYC(P)
    ) dut (
        .C(C),
        .CLRN(CLRN),
        .bus(bus)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: current operation (0 idle, 1 write, 2 preset, 3 init) and its age in cycles.
    int         op;
    int         age;
    logic [3:0] m_d, m_sh;
    logic       m_wack, m_pack;
    logic [3:0] prev_d;
    logic       prev_gn;

    function automatic void model_reset();
        op = 3; age = 0; m_d = 4'h0; m_sh = 4'hF; m_wack = 1'b0; m_pack = 1'b0;
        prev_d = 4'h0; prev_gn = 1'b1;
    endfunction

    function automatic void model_step(logic wr_req, logic pre_req, logic [3:0] wr_data);
        logic blocked;
        blocked = m_wack | m_pack;
        m_wack  = 1'b0;
        m_pack  = 1'b0;
        if (op == 0) begin
            if (!blocked) begin
                if (pre_req) begin
                    op = 2; age = 0;
                end else if (wr_req) begin
                    op = 1; age = 0; m_d = wr_data;
                end
            end
        end else begin
            age++;
            if (op == 1 && age == S + G) m_sh = m_d;
            if (op == 1 && age == S + G + H) begin op = 0; m_wack = 1'b1; end
            if (op == 2 && age == P) begin op = 0; m_sh = 4'hF; m_pack = 1'b1; end
            if (op == 3 && age == P) op = 0;
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        logic gate_open;
        gate_open = (op == 1) && (age >= S) && (age < S + G);
        return {m_wack, m_pack, (op != 0), !gate_open, (op >= 2), m_d, m_sh};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus.WR_ACK, bus.PRE_ACK, bus.BUSY, bus.LAT_GN, bus.LAT_PRE, bus.LAT_D, bus.SHADOW_Q};
    endfunction

    task automatic check(string nm, logic [12:0] act, logic [12:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (ack_w,ack_p,busy,gn,pre,d,shadow)", nm, act, expv);
        end
    endtask

    task automatic check_invariants(string nm);
        logic ok;
        ok = !(!bus.LAT_GN && bus.LAT_PRE);
        check({nm, "_gn_pre_excl"}, {12'd0, ok}, 13'd1);
        ok = !((bus.LAT_D !== prev_d) && (!bus.LAT_GN || !prev_gn));
        check({nm, "_d_stable"}, {12'd0, ok}, 13'd1);
        prev_d  = bus.LAT_D;
        prev_gn = bus.LAT_GN;
    endtask

    task automatic step(string nm);
        @(posedge C);
        model_step(bus.WR_REQ, bus.PRE_REQ, bus.WR_DATA);
        #1;
        check(nm, dut_vec(), exp_vec());
        check_invariants(nm);
    endtask

    // Assert reset 2 time units after an edge, check the immediate effect, hold over one edge.
    task automatic do_reset(string nm);
        #1 CLRN = 1'b0;
        #1;
        model_reset();
        check({nm, "_immediate"}, dut_vec(), exp_vec());
        @(posedge C);
        #1 check({nm, "_held"}, dut_vec(), exp_vec());
        #2 CLRN = 1'b1;
    endtask

    typedef struct {
        logic        wr_req;
        logic        pre_req;
        logic [3:0]  wr_data;
        logic [12:0] expv;  // {wr_ack, pre_ack, busy, lat_gn, lat_pre, lat_d, shadow_q}
    } vec_t;

    vec_t tbl[22];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time bound");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_steps;
        int ack_cnt;
        int ack_at[2];
        logic seen;

        tbl[0]  = '{1'b0, 1'b0, 4'h0, {5'b00111, 4'h0, 4'hF}};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, {5'b00010, 4'h0, 4'hF}};
        tbl[2]  = '{1'b1, 1'b0, 4'hA, {5'b00110, 4'hA, 4'hF}};
        tbl[3]  = '{1'b1, 1'b0, 4'hA, {5'b00100, 4'hA, 4'hF}};
        tbl[4]  = '{1'b1, 1'b0, 4'hA, {5'b00100, 4'hA, 4'hF}};
        tbl[5]  = '{1'b1, 1'b0, 4'hA, {5'b00110, 4'hA, 4'hA}};
        tbl[6]  = '{1'b1, 1'b0, 4'hA, {5'b10010, 4'hA, 4'hA}};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, {5'b00010, 4'hA, 4'hA}};
        tbl[8]  = '{1'b0, 1'b1, 4'h0, {5'b00111, 4'hA, 4'hA}};
        tbl[9]  = '{1'b0, 1'b1, 4'h0, {5'b00111, 4'hA, 4'hA}};
        tbl[10] = '{1'b0, 1'b1, 4'h0, {5'b01010, 4'hA, 4'hF}};
        tbl[11] = '{1'b0, 1'b0, 4'h0, {5'b00010, 4'hA, 4'hF}};
        tbl[12] = '{1'b1, 1'b1, 4'h5, {5'b00111, 4'hA, 4'hF}};
        tbl[13] = '{1'b1, 1'b1, 4'h5, {5'b00111, 4'hA, 4'hF}};
        tbl[14] = '{1'b1, 1'b1, 4'h5, {5'b01010, 4'hA, 4'hF}};
        tbl[15] = '{1'b1, 1'b0, 4'h5, {5'b00010, 4'hA, 4'hF}};
        tbl[16] = '{1'b1, 1'b0, 4'h5, {5'b00110, 4'h5, 4'hF}};
        tbl[17] = '{1'b1, 1'b0, 4'h5, {5'b00100, 4'h5, 4'hF}};
        tbl[18] = '{1'b1, 1'b0, 4'h5, {5'b00100, 4'h5, 4'hF}};
        tbl[19] = '{1'b1, 1'b0, 4'h5, {5'b00110, 4'h5, 4'h5}};
        tbl[20] = '{1'b1, 1'b0, 4'h5, {5'b10010, 4'h5, 4'h5}};
        tbl[21] = '{1'b0, 1'b0, 4'h0, {5'b00010, 4'h5, 4'h5}};

        CLRN = 1'b0;
        bus.WR_REQ = 1'b0; bus.PRE_REQ = 1'b0; bus.WR_DATA = 4'h0;
        model_reset();
        #12;
        check("reset_state", dut_vec(), {5'b00111, 4'h0, 4'hF});
        #1 CLRN = 1'b1;

        // Init, single write of A, preset, then simultaneous requests.
        for (int i = 0; i < 22; i++) begin
            bus.WR_REQ  = tbl[i].wr_req;
            bus.PRE_REQ = tbl[i].pre_req;
            bus.WR_DATA = tbl[i].wr_data;
            @(posedge C);
            model_step(bus.WR_REQ, bus.PRE_REQ, bus.WR_DATA);
            #1;
            check($sformatf("table_row%0d", i), dut_vec(), tbl[i].expv);
            check_invariants($sformatf("table_row%0d", i));
        end

        // WR_DATA changes during the gate window; the captured value must stick.
        bus.WR_REQ = 1'b1; bus.WR_DATA = 4'h3;
        ack_steps = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            step("t4_write");
            if (!bus.LAT_GN) bus.WR_DATA = 4'hC;
            if (bus.WR_ACK) begin seen = 1'b1; ack_steps = i; end
        end
        bus.WR_REQ = 1'b0;
        check("t4_ack_latency", 13'(ack_steps), 13'd5);
        check("t4_data_kept", {5'd0, bus.LAT_D, bus.SHADOW_Q}, {5'd0, 4'h3, 4'h3});
        step("t4_idle");

        // Reset while the gate is open aborts the write without an ACK and replays init.
        bus.WR_REQ = 1'b1; bus.WR_DATA = 4'h7;
        step("t5_accept");
        step("t5_gate");
        check("t5_gate_open", {12'd0, bus.LAT_GN}, 13'd0);
        bus.WR_REQ = 1'b0;
        do_reset("t5_reset");
        for (int i = 0; i < 4; i++) step("t5_replay");

        // Back-to-back writes with WR_REQ held high.
        bus.WR_REQ = 1'b1; bus.WR_DATA = 4'h1;
        ack_cnt = 0; ack_at[0] = 0; ack_at[1] = 0;
        for (int i = 0; i < 30 && ack_cnt < 2; i++) begin
            step("t6_b2b");
            if (bus.WR_ACK) begin
                ack_at[ack_cnt] = i;
                ack_cnt++;
                bus.WR_DATA = 4'h2;
            end
        end
        bus.WR_REQ = 1'b0;
        check("t6_ack_count", 13'(ack_cnt), 13'd2);
        check("t6_ack_spacing", 13'(ack_at[1] - ack_at[0]), 13'd6);
        check("t6_shadow", {9'd0, bus.SHADOW_Q}, 13'h2);
        step("t6_idle");

        // Randomized requests honouring the hold-until-ACK protocol, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                bus.WR_REQ = 1'b0; bus.PRE_REQ = 1'b0;
                do_reset("rand_reset");
            end
            if (bus.WR_ACK) bus.WR_REQ = 1'b0;
            else if (!bus.WR_REQ && $urandom_range(0, 3) == 0) bus.WR_REQ = 1'b1;
            if (bus.PRE_ACK) bus.PRE_REQ = 1'b0;
            else if (!bus.PRE_REQ && $urandom_range(0, 9) == 0) bus.PRE_REQ = 1'b1;
            bus.WR_DATA = 4'($urandom_range(0, 15));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
